elixirchip_es1_spu_op_sub: RTL and testbench

//  SPU subtract op: m_data = s_data0 - s_data1 - borrow, with the ARM-style carry convention
//   (s_carry=1 means no borrow in; m_carry=1 means no borrow out).

---
 rtl/elixirchip_es1_spu_pkg.sv | 16 +
 rtl/elixirchip_es1_spu_delay.sv | 33 +++
 rtl/elixirchip_es1_spu_op_sub.sv | 192 +++++++++++++++++++
 tb/tb_elixirchip_es1_spu_op_sub.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and helpers for the SPU arithmetic ops (add/sub).
// seg_bits() sizes the pipelined carry-chain segments.
package elixirchip_es1_spu_pkg;

  typedef struct packed {
    logic valid;
    logic clear;
  } spu_ctl_t;

  function automatic int seg_bits(input int data_bits, input int latency);
    int n;
    n = (latency < 1) ? 1 : latency;
    return (data_bits + n - 1) / n;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Width/depth shift register with clock enable and optional synchronous reset.
// DEPTH=0 is a plain wire, so callers can describe skew uniformly.
module elixirchip_es1_spu_delay #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter bit               RESET_EN    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cke,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_shift [DEPTH];

    always_ff @(posedge i_clk) begin
      if (RESET_EN && i_reset) begin
        for (int i = 0; i < int'(DEPTH); i++) r_shift[i] <= RESET_VALUE;
      end else if (i_cke) begin
        r_shift[0] <= i_data;
        for (int i = 1; i < int'(DEPTH); i++) r_shift[i] <= r_shift[i-1];
      end
    end

    assign o_data = r_shift[DEPTH-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_sub.sv
// SPU subtract op: {m_carry, m_data} = s_data0 + ~s_data1 + s_carry (ARM carry convention),
// with the carry chain split into LATENCY register-separated segments.
module elixirchip_es1_spu_op_sub
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA      = 'x,
  parameter logic  CLEAR_CARRY     = 1'bx,
  parameter logic  CLEAR_MSB_C     = 1'bx,
  parameter bit    IMMEDIATE_CARRY = 1'b1,
  parameter bit    IMMEDIATE_DATA0 = 1'b0,
  parameter bit    IMMEDIATE_DATA1 = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 s_carry,
  input  logic [DATA_BITS-1:0] s_data0,
  input  logic [DATA_BITS-1:0] s_data1,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry,
  output logic                 m_msb_c
);

  localparam int N    = (LATENCY < 1) ? 1 : LATENCY;
  localparam int SEG  = seg_bits(DATA_BITS, LATENCY);
  // Ceil division can leave trailing stages with no bits; they become pure delay.
  localparam int NSEG = (DATA_BITS + SEG - 1) / SEG;

  localparam logic [DATA_BITS-1:0] ClearData = DATA_BITS'(CLEAR_DATA);

  if (LATENCY > DATA_BITS) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_sub: LATENCY must not exceed DATA_BITS");
  end

  logic [DATA_BITS-1:0] w_res;
  logic                 w_carry;
  logic                 w_msb_c;
  spu_ctl_t             w_ctl_in;
  spu_ctl_t             w_ctl;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO = k * SEG;
    localparam int W  = ((LO + SEG) > DATA_BITS) ? (DATA_BITS - LO) : SEG;
    localparam int DW = (k == NSEG - 1) ? W + 2 : W;

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_cin;
    logic [W:0]    w_sum;
    logic [DW-1:0] w_pre;
    logic [DW-1:0] w_post;

    elixirchip_es1_spu_delay #(
      .WIDTH (W),
      .DEPTH (IMMEDIATE_DATA0 ? 0 : k)
    ) u_skew_a (
      .i_clk   (clk),
      .i_reset (reset),
      .i_cke   (cke),
      .i_data  (s_data0[LO +: W]),
      .o_data  (w_a)
    );

    elixirchip_es1_spu_delay #(
      .WIDTH (W),
      .DEPTH (IMMEDIATE_DATA1 ? 0 : k)
    ) u_skew_b (
      .i_clk   (clk),
      .i_reset (reset),
      .i_cke   (cke),
      .i_data  (s_data1[LO +: W]),
      .o_data  (w_b)
    );

    if (k == 0) begin : g_cin_first
      assign w_cin = s_carry;
    end else begin : g_cin_chain
      assign w_cin = g_seg[k-1].g_mid.r_carry;
    end

    assign w_sum = {1'b0, w_a} + {1'b0, ~w_b} + {{W{1'b0}}, w_cin};

    if (k == NSEG - 1) begin : g_last
      // Carry into the MSB falls out of the top sum bit and its operand bits.
      assign w_pre   = {w_sum[W], w_sum[W-1] ^ w_a[W-1] ^ ~w_b[W-1], w_sum[W-1:0]};
      assign w_carry = w_post[W+1];
      assign w_msb_c = w_post[W];
    end else begin : g_mid
      logic r_carry;
      assign w_pre = w_sum[W-1:0];
      always_ff @(posedge clk) begin
        if (cke) r_carry <= w_sum[W];
      end
    end

    elixirchip_es1_spu_delay #(
      .WIDTH (DW),
      .DEPTH (N - 1 - k)
    ) u_deskew (
      .i_clk   (clk),
      .i_reset (reset),
      .i_cke   (cke),
      .i_data  (w_pre),
      .o_data  (w_post)
    );

    assign w_res[LO +: W] = w_post[W-1:0];
  end

  assign w_ctl_in = '{valid: s_valid, clear: s_clear};

  elixirchip_es1_spu_delay #(
    .WIDTH       ($bits(spu_ctl_t)),
    .DEPTH       (N - 1),
    .RESET_EN    (1'b1),
    .RESET_VALUE ('0)
  ) u_ctl (
    .i_clk   (clk),
    .i_reset (reset),
    .i_cke   (cke),
    .i_data  (w_ctl_in),
    .o_data  (w_ctl)
  );

  if (LATENCY == 0) begin : g_comb_out
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_carry;
    logic                 r_hold_msb_c;

    always_comb begin
      m_data  = r_hold_data;
      m_carry = r_hold_carry;
      m_msb_c = r_hold_msb_c;
      if (w_ctl.clear) begin
        m_data  = ClearData;
        m_carry = CLEAR_CARRY;
        m_msb_c = CLEAR_MSB_C;
      end else if (w_ctl.valid) begin
        m_data  = w_res;
        m_carry = w_carry;
        m_msb_c = w_msb_c;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_hold_data  <= ClearData;
        r_hold_carry <= CLEAR_CARRY;
        r_hold_msb_c <= CLEAR_MSB_C;
      end else if (cke) begin
        r_hold_data  <= m_data;
        r_hold_carry <= m_carry;
        r_hold_msb_c <= m_msb_c;
      end
    end
  end else begin : g_reg_out
    logic [DATA_BITS-1:0] r_data;
    logic                 r_carry;
    logic                 r_msb_c;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_data  <= ClearData;
        r_carry <= CLEAR_CARRY;
        r_msb_c <= CLEAR_MSB_C;
      end else if (cke) begin
        if (w_ctl.clear) begin
          r_data  <= ClearData;
          r_carry <= CLEAR_CARRY;
          r_msb_c <= CLEAR_MSB_C;
        end else if (w_ctl.valid) begin
          r_data  <= w_res;
          r_carry <= w_carry;
          r_msb_c <= w_msb_c;
        end
      end
    end

    assign m_data  = r_data;
    assign m_carry = r_carry;
    assign m_msb_c = r_msb_c;
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sub.sv
// Scoreboard bench: stimulus queues expected results, monitors compare as outputs update.
// Main DUT is 8-bit/LATENCY=2; a 13-bit instance set sweeps LATENCY 0/1/3/13.
module tb_elixirchip_es1_spu_op_sub;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       m;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    res_t       r;
  } vec_t;

  localparam res_t ClearRes = '{d: 8'hAA, c: 1'b0, m: 1'b1};

  logic       clk = 1'b0;
  logic       reset, cke, s_carry, s_clear, s_valid;
  logic [7:0] s_data0, s_data1;
  logic [7:0] m_data;
  logic       m_carry, m_msb_c;

  logic [12:0] a13, b13;
  logic        c13;
  logic        sweep_on;
  logic [12:0] d13  [4];
  logic        co13 [4];
  logic        mc13 [4];

  int n_checks = 0;
  int n_errors = 0;

  res_t           exp_q[$];
  logic [14:0]    hist13[$];

  vec_t vecs [12] = '{
    '{8'h05, 8'h03, 1'b1, '{8'h02, 1'b1, 1'b1}},
    '{8'h03, 8'h05, 1'b1, '{8'hFE, 1'b0, 1'b0}},
    '{8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b0}},
    '{8'h00, 8'h00, 1'b0, '{8'hFF, 1'b0, 1'b0}},
    '{8'h00, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b1}},
    '{8'h7F, 8'hFF, 1'b1, '{8'h80, 1'b0, 1'b1}},
    '{8'hFF, 8'h01, 1'b0, '{8'hFD, 1'b1, 1'b1}},
    '{8'h10, 8'h20, 1'b0, '{8'hEF, 1'b0, 1'b0}},
    '{8'hA5, 8'h5A, 1'b1, '{8'h4B, 1'b1, 1'b0}},
    '{8'h01, 8'h02, 1'b1, '{8'hFF, 1'b0, 1'b0}},
    '{8'hC8, 8'h64, 1'b1, '{8'h64, 1'b1, 1'b0}},
    '{8'h33, 8'h33, 1'b0, '{8'hFF, 1'b0, 1'b0}}
  };

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_sub #(
    .LATENCY     (2),
    .DATA_BITS   (8),
    .CLEAR_DATA  (8'hAA),
    .CLEAR_CARRY (1'b0),
    .CLEAR_MSB_C (1'b1)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .s_carry (s_carry),
    .s_data0 (s_data0),
    .s_data1 (s_data1),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .m_data  (m_data),
    .m_carry (m_carry),
    .m_msb_c (m_msb_c)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 13;
    elixirchip_es1_spu_op_sub #(
      .LATENCY   (L),
      .DATA_BITS (13)
    ) u_dut13 (
      .clk     (clk),
      .reset   (reset),
      .cke     (1'b1),
      .s_carry (c13),
      .s_data0 (a13),
      .s_data1 (b13),
      .s_clear (1'b0),
      .s_valid (1'b1),
      .m_data  (d13[g]),
      .m_carry (co13[g]),
      .m_msb_c (mc13[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] model13(input logic [12:0] a, input logic [12:0] b,
                                          input logic ci);
    logic [13:0] s;
    logic [12:0] lo;
    s  = {1'b0, a} + {1'b0, ~b} + {13'd0, ci};
    lo = {1'b0, a[11:0]} + {1'b0, ~b[11:0]} + {12'd0, ci};
    return {s[12:0], s[13], lo[12]};
  endfunction

  function automatic int lag_of(input int g);
    case (g)
      0, 1:    return 0;
      2:       return 2;
      default: return 12;
    endcase
  endfunction

  // Main monitor: tracks which cke-qualified edge each tagged op reaches the output on.
  res_t last_res;
  logic pend = 1'b0;
  always @(posedge clk) begin
    logic rs, ck, tg;
    rs = reset;
    ck = cke;
    tg = s_valid | s_clear;
    #1;
    if (rs) begin
      exp_q.delete();
      pend     = 1'b0;
      last_res = ClearRes;
      check("reset_outputs", {m_data, m_carry, m_msb_c}, last_res);
    end else if (ck) begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          last_res = exp_q.pop_front();
        end
        check("result", {m_data, m_carry, m_msb_c}, last_res);
      end else begin
        check("hold", {m_data, m_carry, m_msb_c}, last_res);
      end
      pend = tg;
    end else begin
      check("stall_hold", {m_data, m_carry, m_msb_c}, last_res);
    end
  end

  // Sweep monitor: op n13 was sampled at this edge; instance g shows op n13 - lag.
  int n13 = 0;
  always @(posedge clk) begin
    logic on;
    int   lag;
    on = sweep_on;
    #1;
    if (on) begin
      for (int g = 0; g < 4; g++) begin
        lag = lag_of(g);
        if (n13 - lag >= 0) begin
          check($sformatf("sub13_inst%0d_op%0d", g, n13 - lag),
                {d13[g], co13[g], mc13[g]}, hist13[n13 - lag]);
        end
      end
      n13++;
    end
  end

  task automatic op(input int i);
    @(negedge clk);
    reset   = 1'b0;
    cke     = 1'b1;
    s_valid = 1'b1;
    s_clear = 1'b0;
    s_data0 = vecs[i].a;
    s_data1 = vecs[i].b;
    s_carry = vecs[i].ci;
    exp_q.push_back(vecs[i].r);
  endtask

  task automatic stall();
    @(negedge clk);
    cke     = 1'b0;
    s_valid = 1'b1;
    s_data0 = 8'($urandom);
    s_data1 = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      reset   = 1'b0;
      cke     = 1'b1;
      s_valid = 1'b0;
      s_clear = 1'b0;
      s_data0 = 8'($urandom);
    end
  endtask

  task automatic clear_op();
    @(negedge clk);
    cke     = 1'b1;
    s_valid = 1'b1;
    s_clear = 1'b1;
    s_data0 = 8'h77;
    s_data1 = 8'h11;
    exp_q.push_back(ClearRes);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset   = 1'b1;
      s_valid = 1'b0;
      s_clear = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    cke      = 1'b1;
    s_carry  = 1'b0;
    s_clear  = 1'b0;
    s_valid  = 1'b0;
    s_data0  = '0;
    s_data1  = '0;
    a13      = '0;
    b13      = '0;
    c13      = 1'b0;
    sweep_on = 1'b0;
    do_reset(3);

    // Basic subtraction and signed overflow
    op(0); op(1); op(2);
    idle(3);

    // Stream interleaved with cke stalls, then idle gaps that must hold
    for (int i = 3; i < 8; i++) begin
      op(i);
      stall();
    end
    idle(3);

    // Clear with valid between two real ops
    op(8); clear_op(); op(9);
    idle(3);

    // Reset while ops are in flight
    op(10); op(11);
    do_reset(1);
    idle(4);

    // 13-bit latency sweep
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        a13 = '0;
        b13 = '0;
        c13 = 1'b0;
      end else begin
        a13 = 13'($urandom);
        b13 = 13'($urandom);
        c13 = 1'($urandom);
      end
      sweep_on = 1'b1;
      hist13.push_back(model13(a13, b13, c13));
    end
    @(negedge clk);
    sweep_on = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
